// File: rtl/inst_fetch.sv
// Instruction fetch: drives the PC onto the instruction memory and buffers {pc, inst, fault} for decode.
// Latency: an entry is visible one cycle after its pc is presented; a redirect shows its first entry two cycles later.
// Backpressure: the buffer absorbs BUF_DEPTH entries, then the pc stalls; a pop frees a slot in the same cycle.

module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             head_vld,
    output logic [WIDTH-1:0] head_dat,
    output logic             full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // Storage, pointers and occupancy; flush empties the buffer but leaves storage contents alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_vld = (count != '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign head_dat = mem[rd_ptr];
endmodule

module inst_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    BUF_DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_inst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_fault
);
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
        logic                  fault;
    } fetch_ent_t;

    localparam int ENT_W = $bits(fetch_ent_t);

    logic [ADDR_WIDTH-1:0] pc;
    logic                  halted;
    logic                  misaligned;
    logic                  pop;
    logic                  push;
    logic                  full;
    logic                  head_vld;
    fetch_ent_t            wr_ent;
    fetch_ent_t            head_ent;
    logic [ENT_W-1:0]      head_bits;

    assign mem_addr   = pc;
    assign misaligned = (pc[1:0] != 2'b00);
    assign pop        = head_vld & out_ready;
    // Pop-while-full frees the slot being written, so push looks at out_ready combinationally.
    assign push       = !redirect_valid & !halted & (!full | pop);

    // Misaligned fetches are buffered as a fault entry with the instruction zeroed.
    always_comb begin
        wr_ent.pc    = pc;
        wr_ent.inst  = mem_inst;
        wr_ent.fault = 1'b0;
        if (misaligned) begin
            wr_ent.inst  = '0;
            wr_ent.fault = 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push     (push),
        .push_dat (wr_ent),
        .pop      (pop),
        .head_vld (head_vld),
        .head_dat (head_bits),
        .full     (full)
    );

    assign head_ent  = fetch_ent_t'(head_bits);
    assign out_valid = head_vld;
    assign out_pc    = head_ent.pc;
    assign out_inst  = head_ent.inst;
    assign out_fault = head_ent.fault;

    // PC advance and halt-on-fault; a redirect overrides everything and clears the halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            halted <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= redirect_pc;
            halted <= 1'b0;
        end else if (push) begin
            if (misaligned) begin
                halted <= 1'b1;
            end else begin
                pc <= pc + ADDR_WIDTH'(4);
            end
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural instruction memory, scoreboard of expected entries per scenario.
// Latency: entries checked at the falling edge before the handshaking rising edge.
// Backpressure: out_ready is driven per scenario to exercise stall, full and pop-while-full.

module tb_inst_fetch;
    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic [31:0] mem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } ent_t;

    ent_t sb[$];
    ent_t exp_e;
    int   checks   = 0;
    int   failures = 0;

    inst_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0),
        .BUF_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_inst       (mem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .out_fault      (out_fault)
    );

    // mem[k] = 0x1000_0000 + k, word-indexed
    assign mem_inst = 32'h1000_0000 + (mem_addr >> 2);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ent_t mk(input logic [31:0] pc, input logic [31:0] inst, input logic fault);
        ent_t e;
        e.pc = pc; e.inst = inst; e.fault = fault;
        return e;
    endfunction

    // Holds reset for two cycles and releases it on a falling edge.
    task automatic do_reset(input logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = rdy;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || mem_addr !== 32'h0 || out_pc !== 32'h0 ||
            out_inst !== 32'h0 || out_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset: v=%b addr=%h pc=%h inst=%h f=%b, want all zero",
                     out_valid, mem_addr, out_pc, out_inst, out_fault);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_fetch: v=%b pc=%h, want v=1 pc=0", out_valid, out_pc);
        end
    endtask

    task automatic test_stream;
        do_reset(1'b1);
        for (int k = 0; k < 8; k++) sb.push_back(mk(32'(k * 4), 32'h1000_0000 + 32'(k), 1'b0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            exp_e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_e.pc || out_inst !== exp_e.inst || out_fault !== exp_e.fault) begin
                failures++;
                $display("FAIL stream[%0d]: v=%b pc=%h inst=%h f=%b, want pc=%h inst=%h f=%b",
                         k, out_valid, out_pc, out_inst, out_fault, exp_e.pc, exp_e.inst, exp_e.fault);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (mem_addr !== 32'h8) begin
            failures++;
            $display("FAIL bp_stall_early: addr=%h, want 00000008", mem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || mem_addr !== 32'h8) begin
            failures++;
            $display("FAIL bp_stall: v=%b addr=%h, want v=1 addr=00000008", out_valid, mem_addr);
        end
        for (int k = 0; k < 3; k++) sb.push_back(mk(32'(k * 4), 32'h1000_0000 + 32'(k), 1'b0));
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_e.pc || out_inst !== exp_e.inst || out_fault !== exp_e.fault) begin
                failures++;
                $display("FAIL bp_drain[%0d]: v=%b pc=%h inst=%h f=%b, want pc=%h inst=%h f=%b",
                         k, out_valid, out_pc, out_inst, out_fault, exp_e.pc, exp_e.inst, exp_e.fault);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_redirect_full;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || mem_addr !== 32'h40) begin
            failures++;
            $display("FAIL redirect_flush: v=%b addr=%h, want v=0 addr=00000040", out_valid, mem_addr);
        end
        sb.push_back(mk(32'h40, 32'h1000_0010, 1'b0));
        @(negedge clk);
        exp_e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_e.pc || out_inst !== exp_e.inst || out_fault !== exp_e.fault) begin
            failures++;
            $display("FAIL redirect_first: v=%b pc=%h inst=%h f=%b, want pc=%h inst=%h f=%b",
                     out_valid, out_pc, out_inst, out_fault, exp_e.pc, exp_e.inst, exp_e.fault);
        end
    endtask

    task automatic test_fault;
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
        sb.push_back(mk(32'h42, 32'h0, 1'b1));
        @(negedge clk);
        exp_e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_pc !== exp_e.pc || out_inst !== exp_e.inst || out_fault !== exp_e.fault) begin
            failures++;
            $display("FAIL fault_entry: v=%b pc=%h inst=%h f=%b, want pc=%h inst=%h f=%b",
                     out_valid, out_pc, out_inst, out_fault, exp_e.pc, exp_e.inst, exp_e.fault);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || mem_addr !== 32'h42) begin
                failures++;
                $display("FAIL fault_halt[%0d]: v=%b addr=%h, want v=0 addr=00000042", k, out_valid, mem_addr);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clk);
        redirect_valid = 1'b0;
        sb.push_back(mk(32'h80, 32'h1000_0020, 1'b0));
        sb.push_back(mk(32'h84, 32'h1000_0021, 1'b0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp_e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_e.pc || out_inst !== exp_e.inst || out_fault !== exp_e.fault) begin
                failures++;
                $display("FAIL fault_resume[%0d]: v=%b pc=%h inst=%h f=%b, want pc=%h inst=%h f=%b",
                         k, out_valid, out_pc, out_inst, out_fault, exp_e.pc, exp_e.inst, exp_e.fault);
            end
        end
    endtask

    task automatic test_wrap;
        out_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        sb.push_back(mk(32'hFFFF_FFFC, 32'h4FFF_FFFF, 1'b0));
        sb.push_back(mk(32'h0, 32'h1000_0000, 1'b0));
        sb.push_back(mk(32'h4, 32'h1000_0001, 1'b0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_e.pc || out_inst !== exp_e.inst || out_fault !== exp_e.fault) begin
                failures++;
                $display("FAIL wrap[%0d]: v=%b pc=%h inst=%h f=%b, want pc=%h inst=%h f=%b",
                         k, out_valid, out_pc, out_inst, out_fault, exp_e.pc, exp_e.inst, exp_e.fault);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || mem_addr !== 32'h0 || out_pc !== 32'h0 ||
            out_inst !== 32'h0 || out_fault !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: v=%b addr=%h pc=%h inst=%h f=%b, want all zero",
                     out_valid, mem_addr, out_pc, out_inst, out_fault);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        sb.push_back(mk(32'h0, 32'h1000_0000, 1'b0));
        sb.push_back(mk(32'h4, 32'h1000_0001, 1'b0));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp_e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_pc !== exp_e.pc || out_inst !== exp_e.inst || out_fault !== exp_e.fault) begin
                failures++;
                $display("FAIL async_restart[%0d]: v=%b pc=%h inst=%h f=%b, want pc=%h inst=%h f=%b",
                         k, out_valid, out_pc, out_inst, out_fault, exp_e.pc, exp_e.inst, exp_e.fault);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_fault();
        test_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
